lfsr_xbar: RTL and testbench

LFSR_XBAR -- requirements
Module: lfsr_xbar

---
 rtl/lfsr_xbar.sv | 121 ++++++++++++
 tb/tb_lfsr_xbar.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_xbar.sv
// lfsr_xbar: NumIn x NumOut request crossbar. Each target picks one winner
// per cycle by a wrapping priority scan that starts at a priority pointer.
// Load (and optionally store) responses return RespLat cycles after the grant.
// Optional feature macro: LFSR_XBAR_INT_PRIO_EN
//   defined   -> priority pointer comes from an internal 64-bit LFSR and rr_i is ignored
//   undefined -> priority pointer is rr_i and no LFSR logic exists
module lfsr_xbar #(
    parameter int NumIn         = 4,
    parameter int NumOut        = 4,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32,
    parameter int RespLat       = 1,
    parameter int WriteRespOn   = 1,
    localparam int PW           = $clog2(NumIn),
    localparam int AW           = $clog2(NumOut)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [PW-1:0]                        rr_i,
    input  logic [NumIn-1:0]                     req_i,
    input  logic [NumIn-1:0][AW-1:0]             add_i,
    input  logic [NumIn-1:0]                     wen_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]   wdata_i,
    output logic [NumIn-1:0]                     gnt_o,
    output logic [NumIn-1:0][RespDataWidth-1:0]  rdata_o,
    output logic [NumIn-1:0]                     vld_o,
    output logic [NumOut-1:0]                    req_o,
    input  logic [NumOut-1:0]                    gnt_i,
    output logic [NumOut-1:0][ReqDataWidth-1:0]  wdata_o,
    input  logic [NumOut-1:0][RespDataWidth-1:0] rdata_i
);

    logic [PW-1:0]                        w_prio;
    logic [NumOut-1:0]                    w_found;
    logic [NumOut-1:0][PW-1:0]            w_winIdx;
    logic [PW-1:0]                        w_scanIdx;
    logic [NumIn-1:0]                     w_vldD;
    logic [RespLat-1:0][NumIn-1:0][AW-1:0] r_addrPipe;
    logic [RespLat-1:0][NumIn-1:0]        r_vldPipe;

`ifdef LFSR_XBAR_INT_PRIO_EN
    logic [63:0] r_lfsr;
    logic        w_fb;
    logic        w_advance;

    assign w_fb      = r_lfsr[63] ^ r_lfsr[62] ^ r_lfsr[60] ^ r_lfsr[59];
    assign w_advance = |(req_o & gnt_i);

    // LFSR steps once per cycle in which at least one target handshake occurs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr <= 64'h1;
        end else if (w_advance) begin
            r_lfsr <= {r_lfsr[62:0], w_fb};
        end
    end

    assign w_prio = r_lfsr[PW-1:0];
`else
    assign w_prio = rr_i;
`endif

    // Per-target winner: first requesting master at or above w_prio, wrapping
    always_comb begin
        w_found   = '0;
        w_winIdx  = '0;
        w_scanIdx = '0;
        req_o     = '0;
        wdata_o   = '0;
        for (int j = 0; j < NumOut; j++) begin
            for (int k = 0; k < NumIn; k++) begin
                w_scanIdx = w_prio + PW'(k);
                if (!w_found[j] && req_i[w_scanIdx] && (add_i[w_scanIdx] == AW'(j))) begin
                    w_found[j]  = 1'b1;
                    w_winIdx[j] = w_scanIdx;
                end
            end
            req_o[j] = w_found[j];
            if (w_found[j]) begin
                wdata_o[j] = wdata_i[w_winIdx[j]];
            end
        end
    end

    // Master grant: it must be the winner at its target and the target must accept
    always_comb begin
        gnt_o  = '0;
        w_vldD = '0;
        for (int i = 0; i < NumIn; i++) begin
            gnt_o[i]  = req_i[i] && w_found[add_i[i]] &&
                        (w_winIdx[add_i[i]] == PW'(i)) && gnt_i[add_i[i]];
            w_vldD[i] = gnt_o[i] && (!wen_i[i] || (WriteRespOn != 0));
        end
    end

    // Address and valid delay lines that align responses with the slave latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_addrPipe <= '0;
            r_vldPipe  <= '0;
        end else begin
            r_addrPipe[0] <= add_i;
            r_vldPipe[0]  <= w_vldD;
            for (int s = 1; s < RespLat; s++) begin
                r_addrPipe[s] <= r_addrPipe[s-1];
                r_vldPipe[s]  <= r_vldPipe[s-1];
            end
        end
    end

    // Response data is steered from the target addressed RespLat cycles ago
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NumIn; i++) begin
            rdata_o[i] = rdata_i[r_addrPipe[RespLat-1][i]];
        end
    end

    assign vld_o = r_vldPipe[RespLat-1];

endmodule

// File: tb/tb_lfsr_xbar.sv
// tb_lfsr_xbar: directed self-checking bench for lfsr_xbar (4x4, RespLat=1).
// Two instances share all inputs: WriteRespOn=1 (main) and WriteRespOn=0.
// LFSR priority steps are only compiled in when LFSR_XBAR_INT_PRIO_EN is defined.
module tb_lfsr_xbar;

    logic             clk;
    logic             rst;
    logic [1:0]       rr;
    logic [3:0]       req;
    logic [3:0][1:0]  add;
    logic [3:0]       wen;
    logic [3:0][31:0] wdata;
    logic [3:0]       gntI;
    logic [3:0][31:0] rdataI;

    logic [3:0]       gntO,   gntO1;
    logic [3:0][31:0] rdataO, rdataO1;
    logic [3:0]       vldO,   vldO1;
    logic [3:0]       reqO,   reqO1;
    logic [3:0][31:0] wdataO, wdataO1;

    int errors = 0;
    int checks = 0;

    lfsr_xbar #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
                .RespLat(1), .WriteRespOn(1)) dut (
        .clk_i(clk), .rst_i(rst), .rr_i(rr), .req_i(req), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .gnt_o(gntO), .rdata_o(rdataO),
        .vld_o(vldO), .req_o(reqO), .gnt_i(gntI), .wdata_o(wdataO),
        .rdata_i(rdataI)
    );

    lfsr_xbar #(.NumIn(4), .NumOut(4), .ReqDataWidth(32), .RespDataWidth(32),
                .RespLat(1), .WriteRespOn(0)) dutNoWr (
        .clk_i(clk), .rst_i(rst), .rr_i(rr), .req_i(req), .add_i(add),
        .wen_i(wen), .wdata_i(wdata), .gnt_o(gntO1), .rdata_o(rdataO1),
        .vld_o(vldO1), .req_o(reqO1), .gnt_i(gntI), .wdata_o(wdataO1),
        .rdata_i(rdataI)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and reports tag/observed/expected on mismatch
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request pattern; combinational outputs settle 1 time unit later
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0][1:0] a,
                                 input logic [3:0] w, input logic [3:0] g, input logic [1:0] p);
        req  = r;
        add  = a;
        wen  = w;
        gntI = g;
        rr   = p;
        #1;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata[i]  = 32'hA0 + i;
            rdataI[i] = 32'hD0 + i;
        end
        applyStimulus(4'b0000, '0, 4'b0000, 4'b0000, 2'd0);
        checkOutput("reset_vld", 64'(vldO), 64'h0);
        checkOutput("reset_reqo", 64'(reqO), 64'h0);
        checkOutput("reset_wdatao1", 64'(wdataO[1]), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("post_reset_vld", 64'(vldO), 64'h0);

        // Every master on its own target: all granted, data returns next cycle
        applyStimulus(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000, 4'b1111, 2'd0);
        checkOutput("direct_gnt", 64'(gntO), 64'hF);
        checkOutput("direct_reqo", 64'(reqO), 64'hF);
        checkOutput("direct_wdatao2", 64'(wdataO[2]), 64'hA2);
        tick();
        checkOutput("direct_vld", 64'(vldO), 64'hF);
        checkOutput("direct_rdata0", 64'(rdataO[0]), 64'hD0);
        checkOutput("direct_rdata3", 64'(rdataO[3]), 64'hD3);

        // Reversed mapping: responses must follow the registered address
        applyStimulus(4'b1111, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b0000, 4'b1111, 2'd0);
        checkOutput("perm_gnt", 64'(gntO), 64'hF);
        checkOutput("perm_wdatao3", 64'(wdataO[3]), 64'hA0);
        tick();
        checkOutput("perm_rdata0", 64'(rdataO[0]), 64'hD3);
        checkOutput("perm_rdata2", 64'(rdataO[2]), 64'hD1);

`ifndef LFSR_XBAR_INT_PRIO_EN
        // Masters 0 and 2 contend for target 1 under the external pointer
        applyStimulus(4'b0101, {2'd0, 2'd1, 2'd0, 2'd1}, 4'b0000, 4'b1111, 2'd1);
        checkOutput("rr1_gnt", 64'(gntO), 64'h4);
        checkOutput("rr1_wdatao1", 64'(wdataO[1]), 64'hA2);
        checkOutput("rr1_reqo", 64'(reqO), 64'h2);
        checkOutput("rr1_wdatao0_idle", 64'(wdataO[0]), 64'h0);
        applyStimulus(4'b0101, {2'd0, 2'd1, 2'd0, 2'd1}, 4'b0000, 4'b1111, 2'd3);
        checkOutput("rr3_gnt", 64'(gntO), 64'h1);
        checkOutput("rr3_wdatao1", 64'(wdataO[1]), 64'hA0);
        applyStimulus(4'b0101, {2'd0, 2'd1, 2'd0, 2'd1}, 4'b0000, 4'b1111, 2'd2);
        checkOutput("rr2_gnt", 64'(gntO), 64'h4);
        applyStimulus(4'b0101, {2'd0, 2'd1, 2'd0, 2'd1}, 4'b0000, 4'b1111, 2'd0);
        checkOutput("rr0_gnt", 64'(gntO), 64'h1);
        tick();
`endif

        // Target 1 refuses: request still visible, no grant, no response
        applyStimulus(4'b0001, {2'd0, 2'd0, 2'd0, 2'd1}, 4'b0000, 4'b1101, 2'd0);
        checkOutput("blocked_reqo", 64'(reqO), 64'h2);
        checkOutput("blocked_gnt", 64'(gntO), 64'h0);
        tick();
        checkOutput("blocked_vld", 64'(vldO), 64'h0);

        // Granted store: valid only on the WriteRespOn=1 instance
        applyStimulus(4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0001, 4'b1111, 2'd0);
        checkOutput("store_gnt", 64'(gntO), 64'h1);
        checkOutput("store_gnt_nowr", 64'(gntO1), 64'h1);
        tick();
        checkOutput("store_vld_wr1", 64'(vldO), 64'h1);
        checkOutput("store_vld_wr0", 64'(vldO1), 64'h0);

        // Granted load still responds on the WriteRespOn=0 instance
        applyStimulus(4'b0001, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b0000, 4'b1111, 2'd0);
        tick();
        checkOutput("load_vld_wr0", 64'(vldO1), 64'h1);
        checkOutput("load_rdata_wr0", 64'(rdataO1[0]), 64'hD2);

        // Reset mid-stream while a response is pending
        checkOutput("pending_vld", 64'(vldO), 64'h1);
        rst = 1'b1;
        #1;
        checkOutput("midreset_vld", 64'(vldO), 64'h0);
        checkOutput("midreset_vld_wr0", 64'(vldO1), 64'h0);
        checkOutput("midreset_gnt_comb", 64'(gntO), 64'h1);
        applyStimulus(4'b0000, '0, 4'b0000, 4'b1111, 2'd0);
        rst = 1'b0;
        tick();
        checkOutput("after_reset_vld", 64'(vldO), 64'h0);

`ifdef LFSR_XBAR_INT_PRIO_EN
        // LFSR restarted at 1: prio 1, master 1 beats master 0 (rr_i ignored)
        applyStimulus(4'b0011, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 4'b1111, 2'd3);
        checkOutput("lfsr_restart_gnt", 64'(gntO), 64'h2);
        tick();
        // State 2 -> prio 2: masters 1 and 2 contend, master 2 wins
        applyStimulus(4'b0110, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 4'b1111, 2'd1);
        checkOutput("lfsr_prio2_gnt", 64'(gntO), 64'h4);
        tick();
        // Request without handshake and an idle cycle: LFSR must hold at 4
        applyStimulus(4'b0110, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 4'b1110, 2'd2);
        checkOutput("lfsr_nohs_gnt", 64'(gntO), 64'h0);
        tick();
        applyStimulus(4'b0000, '0, 4'b0000, 4'b1111, 2'd2);
        tick();
        // State 4 -> prio 0: master 1 wins over master 2
        applyStimulus(4'b0110, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 4'b1111, 2'd2);
        checkOutput("lfsr_prio0a_gnt", 64'(gntO), 64'h2);
        tick();
        // State 8 -> prio 0 again
        checkOutput("lfsr_prio0b_gnt", 64'(gntO), 64'h2);
        tick();
        // Reset restarts the LFSR: master 1 wins the first 0-vs-1 contention
        rst = 1'b1;
        #1;
        applyStimulus(4'b0011, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0000, 4'b1111, 2'd0);
        rst = 1'b0;
        #1;
        checkOutput("lfsr_rereset_gnt", 64'(gntO), 64'h2);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
